// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer for RISC-V loads/stores.
// Checks alignment and range, drives a ready/valid DMEM request, formats
// store lanes/strobes, extends load data and reports LAM/LAF/SAM/SAF.
// Ports:
//   CLK, RESET_N (sync, active low)
//   MEM_V/LOAD/STORE/FUNCT3/ADDR/WDATA : op from MEM stage
//   WB_STALL                           : WB back-pressure
//   MEM_STALL/DONE/RESULT, MEM_LAM/LAF/SAM/SAF : status to pipeline
//   DMEM_REQ/WE/ADDR/WDATA/WSTRB -> memory, DMEM_READY/RDATA/ERR <- memory
module mem_access_ctrl #(
    parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000,
    parameter int          TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_V,
    input  logic        MEM_LOAD,
    input  logic        MEM_STORE,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [63:0] MEM_ADDR,
    input  logic [63:0] MEM_WDATA,
    input  logic        WB_STALL,
    output logic        MEM_STALL,
    output logic        MEM_DONE,
    output logic [63:0] MEM_RESULT,
    output logic        MEM_LAM,
    output logic        MEM_LAF,
    output logic        MEM_SAM,
    output logic        MEM_SAF,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic [7:0]  DMEM_WSTRB,
    input  logic        DMEM_READY,
    input  logic [63:0] DMEM_RDATA,
    input  logic        DMEM_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        ld_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  off_q;

    logic        op;
    logic        misal;
    logic        range_flt;
    logic [2:0]  off;
    logic [7:0]  bmask;
    logic [7:0]  st_strb;
    logic [63:0] st_data;
    logic [63:0] ld_shift;
    logic [63:0] ld_data;

    // Load wins when both LOAD and STORE are asserted.
    assign op        = MEM_V & (MEM_LOAD | MEM_STORE);
    assign off       = MEM_ADDR[2:0];
    assign range_flt = (MEM_ADDR >= ADDR_LIMIT);

    always_comb begin
        misal = 1'b0;
        bmask = 8'h00;
        unique case (MEM_FUNCT3[1:0])
            2'd0: begin
                misal = 1'b0;
                bmask = 8'h01;
            end
            2'd1: begin
                misal = off[0];
                bmask = 8'h03;
            end
            2'd2: begin
                misal = |off[1:0];
                bmask = 8'h0F;
            end
            2'd3: begin
                misal = |off;
                bmask = 8'hFF;
            end
            default: begin
                misal = 1'b0;
                bmask = 8'h00;
            end
        endcase
    end

    assign st_strb = bmask << off;
    assign st_data = MEM_WDATA << {off, 3'b000};

    // Load extraction uses the offset/size captured when ACCESS was entered.
    assign ld_shift = DMEM_RDATA >> {off_q, 3'b000};

    always_comb begin
        ld_data = 64'h0;
        unique case (size_q)
            2'd0: ld_data = uns_q ? {56'h0, ld_shift[7:0]}
                                  : {{56{ld_shift[7]}}, ld_shift[7:0]};
            2'd1: ld_data = uns_q ? {48'h0, ld_shift[15:0]}
                                  : {{48{ld_shift[15]}}, ld_shift[15:0]};
            2'd2: ld_data = uns_q ? {32'h0, ld_shift[31:0]}
                                  : {{32{ld_shift[31]}}, ld_shift[31:0]};
            2'd3: ld_data = ld_shift;
            default: ld_data = 64'h0;
        endcase
    end

    always_comb begin
        MEM_STALL = 1'b0;
        MEM_DONE  = 1'b0;
        unique case (state)
            IDLE:    MEM_STALL = op;
            ACCESS:  MEM_STALL = 1'b1;
            DONE: begin
                MEM_STALL = WB_STALL;
                MEM_DONE  = ~WB_STALL;
            end
            default: begin
                MEM_STALL = 1'b0;
                MEM_DONE  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cnt        <= 8'h0;
            ld_q       <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            off_q      <= 3'd0;
            MEM_RESULT <= 64'h0;
            MEM_LAM    <= 1'b0;
            MEM_LAF    <= 1'b0;
            MEM_SAM    <= 1'b0;
            MEM_SAF    <= 1'b0;
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= 64'h0;
            DMEM_WDATA <= 64'h0;
            DMEM_WSTRB <= 8'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op) begin
                        ld_q   <= MEM_LOAD;
                        size_q <= MEM_FUNCT3[1:0];
                        uns_q  <= MEM_FUNCT3[2];
                        off_q  <= off;
                        if (misal) begin
                            state   <= DONE;
                            MEM_LAM <= MEM_LOAD;
                            MEM_SAM <= ~MEM_LOAD;
                        end else if (range_flt) begin
                            state   <= DONE;
                            MEM_LAF <= MEM_LOAD;
                            MEM_SAF <= ~MEM_LOAD;
                        end else begin
                            state      <= ACCESS;
                            cnt        <= 8'h0;
                            DMEM_REQ   <= 1'b1;
                            DMEM_WE    <= ~MEM_LOAD;
                            DMEM_ADDR  <= {MEM_ADDR[63:3], 3'b000};
                            DMEM_WDATA <= MEM_LOAD ? 64'h0 : st_data;
                            DMEM_WSTRB <= MEM_LOAD ? 8'h0 : st_strb;
                        end
                    end
                end
                ACCESS: begin
                    // READY on the timeout cycle still completes normally.
                    if (DMEM_READY || cnt == TO_LAST) begin
                        state      <= DONE;
                        DMEM_REQ   <= 1'b0;
                        DMEM_WE    <= 1'b0;
                        DMEM_ADDR  <= 64'h0;
                        DMEM_WDATA <= 64'h0;
                        DMEM_WSTRB <= 8'h0;
                        if (!DMEM_READY || DMEM_ERR) begin
                            MEM_LAF <= ld_q;
                            MEM_SAF <= ~ld_q;
                        end else if (ld_q) begin
                            MEM_RESULT <= ld_data;
                        end
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                DONE: begin
                    if (!WB_STALL) begin
                        state      <= IDLE;
                        MEM_RESULT <= 64'h0;
                        MEM_LAM    <= 1'b0;
                        MEM_LAF    <= 1'b0;
                        MEM_SAM    <= 1'b0;
                        MEM_SAF    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
